// File: rtl/redundancy_pair_scanner_pkg.sv
// Shared types and defaults for the redundancy pair scanner.
package redundancy_pair_scanner_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 8;
  localparam int unsigned DEF_MAX_C_SIZE = 128;
  localparam int unsigned DEF_IDX_WIDTH  = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Number of i<j pairs in a chunk of n words.
  function automatic int unsigned pair_count(input int unsigned n);
    return (n < 2) ? 0 : (n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/redundancy_pair_scanner_pair_output_reg.sv
// Single-entry valid/ready register holding one (idx1, idx2) pair.
// free_c tells the producer a new pair can be loaded this cycle.
module pair_output_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] load_idx1,
  input  logic [WIDTH-1:0] load_idx2,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] idx1,
  output logic [WIDTH-1:0] idx2,
  output logic             free_c
);

  assign free_c = !valid || ready;

  // Load on push, otherwise drop valid once the consumer takes the pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      idx1  <= '0;
      idx2  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      idx1  <= load_idx1;
      idx2  <= load_idx2;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/redundancy_pair_scanner.sv
// Buffers one chunk of words, compares all pairs i<j and streams out
// every equal pair as (idx1=i, idx2=j).
// Optional feature macro: REDUNDANCY_FIRST_MATCH_EN -- report each redundant
// index only once, against its earliest equal index.
module redundancy_pair_scanner
  import redundancy_pair_scanner_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned MAX_C_SIZE = DEF_MAX_C_SIZE,
  parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_WIDTH:0]    c_size,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WORD_WIDTH-1:0] load_data,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic [WORD_WIDTH-1:0] idx1,
  output logic [WORD_WIDTH-1:0] idx2,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW = IDX_WIDTH + 1;

  state_t state, next_state;

  logic [WORD_WIDTH-1:0] mem [MAX_C_SIZE];
  logic [IDX_WIDTH-1:0]  load_cnt, i, j, last, last_row, last_in;
  logic [CW-1:0]         size_clamp;
  logic                  load_fire, scan_step, row_skip, push;
  logic                  eq, last_pair, free_c;

`ifdef REDUNDANCY_FIRST_MATCH_EN
  logic [MAX_C_SIZE-1:0] matched;
  logic                  mark;
`endif

  assign size_clamp = (c_size > CW'(MAX_C_SIZE)) ? CW'(MAX_C_SIZE) : c_size;
  assign last_in    = IDX_WIDTH'(size_clamp - CW'(1));
  assign last_row   = last - IDX_WIDTH'(1);
  assign eq         = (mem[i] == mem[j]);
  assign last_pair  = (i == last_row) && (j == last);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle scan actions.
  always_comb begin
    next_state = state;
    load_fire  = 1'b0;
    scan_step  = 1'b0;
    row_skip   = 1'b0;
    push       = 1'b0;
`ifdef REDUNDANCY_FIRST_MATCH_EN
    mark       = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) next_state = (c_size < CW'(2)) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (load_valid) begin
          load_fire = 1'b1;
          if (load_cnt == last) next_state = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef REDUNDANCY_FIRST_MATCH_EN
        // Already-reported rows and columns are skipped without a compare.
        if (matched[i]) begin
          row_skip = 1'b1;
          if (i == last_row) next_state = S_DRAIN;
        end else if (matched[j]) begin
          scan_step = 1'b1;
          if (last_pair) next_state = S_DRAIN;
        end else if (free_c) begin
          scan_step = 1'b1;
          push      = eq;
          mark      = eq;
          if (last_pair) next_state = S_DRAIN;
        end
`else
        if (free_c) begin
          scan_step = 1'b1;
          push      = eq;
          if (last_pair) next_state = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        if (free_c) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      load_ready <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy       <= (next_state != S_IDLE);
      load_ready <= (next_state == S_LOAD);
      done       <= (next_state == S_DONE);
    end
  end

  // Load counter and (i, j) scan indices.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt <= '0;
      last     <= '0;
      i        <= '0;
      j        <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        load_cnt <= '0;
        last     <= last_in;
        i        <= '0;
        j        <= IDX_WIDTH'(1);
      end
      if (load_fire) load_cnt <= load_cnt + IDX_WIDTH'(1);
      if (row_skip || (scan_step && j == last)) begin
        i <= i + IDX_WIDTH'(1);
        j <= i + IDX_WIDTH'(2);
      end else if (scan_step) begin
        j <= j + IDX_WIDTH'(1);
      end
    end
  end

  // Chunk buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_fire) mem[load_cnt] <= load_data;
  end

`ifdef REDUNDANCY_FIRST_MATCH_EN
  // Bitmap of indices already reported as redundant.
  always_ff @(posedge clk) begin
    if (reset)                        matched    <= '0;
    else if (state == S_IDLE && start) matched    <= '0;
    else if (mark)                    matched[j] <= 1'b1;
  end
`endif

  pair_output_reg #(.WIDTH(WORD_WIDTH)) u_out (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .load_idx1 (WORD_WIDTH'(i)),
    .load_idx2 (WORD_WIDTH'(j)),
    .ready     (pair_ready),
    .valid     (pair_valid),
    .idx1      (idx1),
    .idx2      (idx2),
    .free_c    (free_c)
  );

endmodule

// File: tb/tb_redundancy_pair_scanner.sv
// Directed bench for redundancy_pair_scanner (default and first-match builds).
module tb_redundancy_pair_scanner;
  import redundancy_pair_scanner_pkg::*;

`ifdef REDUNDANCY_FIRST_MATCH_EN
  localparam bit FM = 1'b1;
`else
  localparam bit FM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, load_valid, load_ready, pair_valid, pair_ready, busy, done;
  logic [7:0] c_size, load_data, idx1, idx2;

  int total = 0;
  int bad   = 0;
  int done_cyc;
  logic pv_at_done;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  logic [7:0]  dat[$];

  always #5 clk = ~clk;

  redundancy_pair_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .c_size     (c_size),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .idx1       (idx1),
    .idx2       (idx2),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cmp_pairs(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      chk($sformatf("%s_pair%0d", tag, k), 32'(got[k]), 32'(exp_q[k]));
  endtask

  task automatic load_words(input bit pulse_start);
    for (int k = 0; k < dat.size(); k++) begin
      load_valid = 1'b1;
      load_data  = dat[k];
      if (pulse_start && k == 1) begin
        start  = 1'b1;
        c_size = 8'd0;
      end
      @(negedge clk);
      start = 1'b0;
    end
    load_valid = 1'b0;
  endtask

  // Start a chunk from dat, load it, collect transferred pairs until done.
  task automatic run_chunk(input string tag, input int stall, input int start_at);
    int stall_left;
    stall_left = stall;
    got.delete();
    done_cyc   = -1;
    pv_at_done = 1'bx;
    c_size = 8'(dat.size());
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    load_words(start_at >= 0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      start = (cyc == start_at);
      if (start) c_size = 8'd2;
      if (pair_valid && stall_left > 0) begin
        pair_ready = 1'b0;
        chk({tag, "_hold_idx1"}, 32'(idx1), 32'd0);
        chk({tag, "_hold_idx2"}, 32'(idx2), 32'd2);
        stall_left--;
      end else begin
        pair_ready = 1'b1;
      end
      if (pair_valid && pair_ready) got.push_back({idx1, idx2});
      if (done) begin
        done_cyc   = cyc;
        pv_at_done = pair_valid;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    chk({tag, "_pv_at_done"}, 32'(pv_at_done), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_shot"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; c_size = 8'd0;
    load_valid = 1'b0; load_data = 8'd0; pair_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_idx1",       32'(idx1),       32'd0);
    chk("rst_idx2",       32'(idx2),       32'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: {5,3,5,7,5}
    dat = '{8'd5, 8'd3, 8'd5, 8'd7, 8'd5};
    if (FM) exp_q = '{16'h0002, 16'h0004};
    else    exp_q = '{16'h0002, 16'h0004, 16'h0204};
    run_chunk("t1", 0, -1);
    cmp_pairs("t1");
    chk("t1_done_cyc", 32'(done_cyc), FM ? 32'd10 : 32'(pair_count(5) + 1));

    // T2: all equal
    dat = '{8'd9, 8'd9, 8'd9, 8'd9};
    if (FM) exp_q = '{16'h0001, 16'h0002, 16'h0003};
    else    exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0102, 16'h0103, 16'h0203};
    run_chunk("t2", 0, -1);
    cmp_pairs("t2");
    chk("t2_done_cyc", 32'(done_cyc), FM ? 32'd6 : 32'd7);

    // T3: T1 with 3 stall cycles on the first pair
    dat = '{8'd5, 8'd3, 8'd5, 8'd7, 8'd5};
    if (FM) exp_q = '{16'h0002, 16'h0004};
    else    exp_q = '{16'h0002, 16'h0004, 16'h0204};
    run_chunk("t3", 3, -1);
    cmp_pairs("t3");
    chk("t3_done_cyc", 32'(done_cyc), FM ? 32'd13 : 32'd14);

    // T4: degenerate sizes go straight to done, loads ignored
    for (int s = 0; s < 2; s++) begin
      c_size = 8'(1 - s);
      start = 1'b1;
      load_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("t4_c%0d_done", 1 - s),       32'(done),       32'd1);
      chk($sformatf("t4_c%0d_load_ready", 1 - s), 32'(load_ready), 32'd0);
      chk($sformatf("t4_c%0d_pair_valid", 1 - s), 32'(pair_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("t4_c%0d_done_end", 1 - s),   32'(done),       32'd0);
      chk($sformatf("t4_c%0d_busy_end", 1 - s),   32'(busy),       32'd0);
      chk($sformatf("t4_c%0d_lr_end", 1 - s),     32'(load_ready), 32'd0);
      load_valid = 1'b0;
    end

    // T5: reset in SCAN with a pending pair, then rerun T1
    dat = '{8'd5, 8'd3, 8'd5, 8'd7, 8'd5};
    c_size = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_words(1'b0);
    pair_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (pair_valid) break;
      @(negedge clk);
    end
    chk("t5_pending", 32'(pair_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pair_ready = 1'b1;
    chk("t5_rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("t5_rst_busy",       32'(busy),       32'd0);
    chk("t5_rst_idx2",       32'(idx2),       32'd0);
    if (FM) exp_q = '{16'h0002, 16'h0004};
    else    exp_q = '{16'h0002, 16'h0004, 16'h0204};
    run_chunk("t5", 0, -1);
    cmp_pairs("t5");
    chk("t5_done_cyc", 32'(done_cyc), FM ? 32'd10 : 32'd11);

    // T6: stray start pulses during LOAD and SCAN, distinct data
    dat = '{8'd1, 8'd2, 8'd3, 8'd4};
    exp_q.delete();
    run_chunk("t6", 0, 2);
    cmp_pairs("t6");
    chk("t6_done_cyc", 32'(done_cyc), 32'(pair_count(4) + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
